// File: rtl/wide_add_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wide_add_sequencer_pkg
// Description : Shared state encoding, default word width and index sizing
//               for the wide add/sub sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package wide_add_sequencer_pkg;

    localparam int c_WORD = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Index register width; never narrower than one bit.
    function automatic int idx_width(input int nwords);
        return (nwords < 2) ? 1 : $clog2(nwords);
    endfunction

endpackage
`default_nettype wire

// File: rtl/wide_add_sequencer_word_select.sv
`default_nettype none
// ============================================================================
// Module      : wide_add_sequencer_word_select
// Description : Combinational NWORDS:1 word mux with optional inversion and a
//               zeroing enable.
// Revision    : 1.0 - initial release
// ============================================================================
module wide_add_sequencer_word_select #(
    parameter int WORD   = 16,
    parameter int NWORDS = 4,
    parameter int IW     = 2
) (
    input  logic [WORD*NWORDS-1:0] data,
    input  logic [IW-1:0]          sel,
    input  logic                   invert,
    input  logic                   enable,
    output logic [WORD-1:0]        word
);

    logic [WORD-1:0] w_words [NWORDS];
    logic [WORD-1:0] w_sel;

    genvar gi;
    generate
        for (gi = 0; gi < NWORDS; gi++) begin : g_unpack
            assign w_words[gi] = data[gi*WORD +: WORD];
        end
    endgenerate

    // Compare-based select keeps out-of-range sel values (non power-of-two
    // NWORDS) well defined as zero.
    always_comb begin
        w_sel = '0;
        for (int i = 0; i < NWORDS; i++) begin
            if (sel == IW'(i)) begin
                w_sel = w_words[i];
            end
        end
    end

    always_comb begin
        word = '0;
        if (enable) begin
            word = invert ? ~w_sel : w_sel;
        end
    end

endmodule
`default_nettype wire

// File: rtl/wide_add_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : wide_add_sequencer
// Description : Feeds two latched wide operands word-serially to an external
//               WORD-bit adder, chaining carries and collecting the result.
// Revision    : 1.0 - initial release
// ============================================================================
module wide_add_sequencer
    import wide_add_sequencer_pkg::*;
#(
    parameter int WORD   = c_WORD,
    parameter int NWORDS = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   sub,
    input  logic                   cin,
    input  logic [WORD*NWORDS-1:0] op_a,
    input  logic [WORD*NWORDS-1:0] op_b,
    output logic [WORD-1:0]        add_a,
    output logic [WORD-1:0]        add_b,
    output logic                   add_cin,
    input  logic [WORD-1:0]        add_sum,
    input  logic                   add_carry,
    output logic                   busy,
    output logic                   done,
    output logic [WORD*NWORDS-1:0] result,
    output logic                   cout,
    output logic                   ovf
);

    localparam int            IW     = idx_width(NWORDS);
    localparam logic [IW-1:0] c_LAST = IW'(NWORDS - 1);

    state_t                  r_state;
    logic [IW-1:0]           r_idx;
    logic                    r_carry;
    logic                    r_sub;
    logic [WORD*NWORDS-1:0]  r_a;
    logic [WORD*NWORDS-1:0]  r_b;
    logic [WORD*NWORDS-1:0]  r_result;
    logic                    r_cout;
    logic                    r_ovf;
    logic                    r_busy;
    logic                    r_done;

    logic                    w_run;
    logic                    w_accept;
    logic                    w_ovf;

    assign w_run    = (r_state == RUN);
    assign w_accept = start && ((r_state == IDLE) || (r_state == DONE));

    wide_add_sequencer_word_select #(
        .WORD   (WORD),
        .NWORDS (NWORDS),
        .IW     (IW)
    ) u_sel_a (
        .data   (r_a),
        .sel    (r_idx),
        .invert (1'b0),
        .enable (w_run),
        .word   (add_a)
    );

    wide_add_sequencer_word_select #(
        .WORD   (WORD),
        .NWORDS (NWORDS),
        .IW     (IW)
    ) u_sel_b (
        .data   (r_b),
        .sel    (r_idx),
        .invert (r_sub),
        .enable (w_run),
        .word   (add_b)
    );

    assign add_cin = w_run ? r_carry : 1'b0;

    // add_b is already the effective (possibly inverted) operand word.
    assign w_ovf = (add_a[WORD-1] == add_b[WORD-1]) &&
                   (add_sum[WORD-1] != add_a[WORD-1]);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_idx    <= '0;
            r_carry  <= 1'b0;
            r_sub    <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    r_done <= 1'b0;
                    if (w_accept) begin
                        r_a      <= op_a;
                        r_b      <= op_b;
                        r_sub    <= sub;
                        r_result <= '0;
                        r_carry  <= sub ? 1'b1 : cin;
                        r_idx    <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= RUN;
                    end else begin
                        r_state  <= IDLE;
                    end
                end
                RUN: begin
                    for (int i = 0; i < NWORDS; i++) begin
                        if (r_idx == IW'(i)) begin
                            r_result[i*WORD +: WORD] <= add_sum;
                        end
                    end
                    r_carry <= add_carry;
                    if (r_idx == c_LAST) begin
                        r_cout  <= add_carry;
                        r_ovf   <= w_ovf;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_idx   <= r_idx + IW'(1);
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;
    assign cout   = r_cout;
    assign ovf    = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_wide_add_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_wide_add_sequencer
// Description : Directed self-checking bench with a behavioural 16-bit adder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wide_add_sequencer;

    localparam int c_W = 64;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             sub;
    logic             cin;
    logic [c_W-1:0]   op_a;
    logic [c_W-1:0]   op_b;
    logic [15:0]      add_a;
    logic [15:0]      add_b;
    logic             add_cin;
    logic [15:0]      add_sum;
    logic             add_carry;
    logic             busy;
    logic             done;
    logic [c_W-1:0]   result;
    logic             cout;
    logic             ovf;

    int               n_tests = 0;
    int               n_fail  = 0;
    int               cyc     = 0;
    int               t_done  = 0;
    logic             cin_log [4];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Downstream adder stand-in.
    assign {add_carry, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {16'd0, add_cin};

    wide_add_sequencer #(
        .WORD   (16),
        .NWORDS (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .sub       (sub),
        .cin       (cin),
        .op_a      (op_a),
        .op_b      (op_b),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_sum   (add_sum),
        .add_carry (add_carry),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .cout      (cout),
        .ovf       (ovf)
    );

    task automatic chk(input string tag, input logic [c_W-1:0] obs, input logic [c_W-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a start for one edge; returns one cycle after the accepting edge.
    task automatic launch(input logic [c_W-1:0] a, input logic [c_W-1:0] b,
                          input logic s, input logic c);
        op_a  = a;
        op_b  = b;
        sub   = s;
        cin   = c;
        start = 1'b1;
        step();
        start = 1'b0;
        op_a  = ~a;
        op_b  = ~b;
        cin   = ~c;
    endtask

    // Checks RUN cycles 1..4 and the DONE cycle; returns while still in DONE.
    task automatic run_check(input string tag, input logic [c_W-1:0] exp_res,
                             input logic exp_cout, input logic exp_ovf, input bit inject);
        for (int k = 1; k <= 4; k++) begin
            chk({tag, "_busy"}, {63'd0, busy}, 64'd1);
            chk({tag, "_nodone"}, {63'd0, done}, 64'd0);
            cin_log[k-1] = add_cin;
            if (inject && k == 2) begin
                start = 1'b1;
                op_a  = 64'h1111_2222_3333_4444;
                op_b  = 64'h5555_6666_7777_8888;
                sub   = 1'b1;
            end
            step();
            if (inject && k == 2) start = 1'b0;
        end
        t_done = cyc;
        chk({tag, "_done"}, {63'd0, done}, 64'd1);
        chk({tag, "_dbusy"}, {63'd0, busy}, 64'd0);
        chk({tag, "_result"}, result, exp_res);
        chk({tag, "_cout"}, {63'd0, cout}, {63'd0, exp_cout});
        chk({tag, "_ovf"}, {63'd0, ovf}, {63'd0, exp_ovf});
        chk({tag, "_idle_a"}, {48'd0, add_a}, 64'd0);
    endtask

    initial begin
        int t_first;
        reset = 1'b1;
        start = 1'b0;
        sub   = 1'b0;
        cin   = 1'b0;
        op_a  = '0;
        op_b  = '0;
        step();
        step();
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_result", result, 64'd0);
        chk("rst_cout", {63'd0, cout}, 64'd0);
        chk("rst_ovf", {63'd0, ovf}, 64'd0);
        chk("rst_add_a", {48'd0, add_a}, 64'd0);
        chk("rst_add_b", {48'd0, add_b}, 64'd0);
        chk("rst_add_cin", {63'd0, add_cin}, 64'd0);
        reset = 1'b0;
        step();

        // Word-0 carry into word 1
        launch(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0);
        run_check("add_carry1", 64'h0000_0000_0001_0000, 1'b0, 1'b0, 1'b0);
        step();
        chk("add_carry1_idle", {63'd0, done}, 64'd0);

        // Full ripple
        launch(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
        run_check("ripple", 64'h0, 1'b1, 1'b0, 1'b0);
        chk("ripple_cin0", {63'd0, cin_log[0]}, 64'd0);
        chk("ripple_cin1", {63'd0, cin_log[1]}, 64'd1);
        chk("ripple_cin2", {63'd0, cin_log[2]}, 64'd1);
        chk("ripple_cin3", {63'd0, cin_log[3]}, 64'd1);
        step();

        // add with cin=1
        launch(64'h0000_0000_0000_0010, 64'h0000_0000_0000_0020, 1'b0, 1'b1);
        run_check("add_cin", 64'h31, 1'b0, 1'b0, 1'b0);
        chk("add_cin_w0", {63'd0, cin_log[0]}, 64'd1);
        step();

        // Subtraction, borrow and no-borrow
        launch(64'd5, 64'd7, 1'b1, 1'b0);
        run_check("sub_5_7", 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0);
        step();
        launch(64'd7, 64'd5, 1'b1, 1'b0);
        run_check("sub_7_5", 64'd2, 1'b1, 1'b0, 1'b0);
        step();

        // Signed overflow cases
        launch(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
        run_check("ovf_pos", 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0);
        step();
        launch(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0);
        run_check("ovf_neg", 64'h0, 1'b1, 1'b1, 1'b0);
        step();

        // Reset in the second RUN cycle
        launch(64'h0000_0000_0000_1234, 64'h0000_0000_0000_1111, 1'b0, 1'b0);
        chk("abort_busy1", {63'd0, busy}, 64'd1);
        step();
        chk("abort_partial", result, 64'h0000_0000_0000_2345);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_done", {63'd0, done}, 64'd0);
        chk("abort_result", result, 64'd0);
        chk("abort_add_a", {48'd0, add_a}, 64'd0);
        chk("abort_add_b", {48'd0, add_b}, 64'd0);
        chk("abort_add_cin", {63'd0, add_cin}, 64'd0);
        step();
        chk("abort_nodone", {63'd0, done}, 64'd0);
        launch(64'h0001_0002_0003_0004, 64'h0010_0020_0030_0040, 1'b0, 1'b0);
        run_check("post_abort", 64'h0011_0022_0033_0044, 1'b0, 1'b0, 1'b0);
        step();

        // start during RUN is ignored
        launch(64'h0000_0000_0000_0009, 64'h0000_0000_0000_0003, 1'b1, 1'b0);
        run_check("ignore", 64'd6, 1'b1, 1'b0, 1'b1);
        step();
        chk("ignore_idle_busy", {63'd0, busy}, 64'd0);

        // Back-to-back: second start held in the DONE cycle
        launch(64'h0000_0000_0000_0100, 64'h0000_0000_0000_0023, 1'b0, 1'b0);
        run_check("b2b_first", 64'h123, 1'b0, 1'b0, 1'b0);
        t_first = t_done;
        launch(64'h0000_0001_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
        run_check("b2b_second", 64'h0000_0000_FFFF_FFFF, 1'b1, 1'b0, 1'b0);
        chk("b2b_spacing", 64'(t_done - t_first), 64'd5);
        step();
        chk("b2b_end_done", {63'd0, done}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
